vx_hpdcache_mem_req_arb: RTL and testbench

Request-side front stage between the HPDcache memory ports and the single Vortex memory bus. Pairs the independent write-address and write-data channels, arbitrates round-robin between reads and paired writes, and registers the winner onto the bus. Routes bus responses back to the read-response channel. Because the bus returns nothing for writes, it generates write acknowledgements locally once each write has been issued.

---
 rtl/vx_hpdcache_mem_req_arb.sv | 174 +++++++++++++++++
 tb/tb_vx_hpdcache_mem_req_arb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vx_hpdcache_mem_req_arb.sv
// HPDcache-to-Vortex request front stage: pairs write address/data, round-robin
// arbitrates reads against writes into a registered bus slot, and acks writes locally.
module vx_hpdcache_mem_req_arb #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 512,
    parameter int ID_WIDTH     = 4,
    parameter int TAG_WIDTH    = ID_WIDTH + 1,
    parameter int WR_ACK_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
    input  logic [ID_WIDTH-1:0]     rd_req_id,

    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_req_addr,
    input  logic [ID_WIDTH-1:0]     wr_req_id,

    input  logic                    wr_data_valid,
    output logic                    wr_data_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    output logic [TAG_WIDTH-1:0]    mem_req_tag,

    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,

    output logic                    rd_rsp_valid,
    input  logic                    rd_rsp_ready,
    output logic [ID_WIDTH-1:0]     rd_rsp_id,
    output logic [DATA_WIDTH-1:0]   rd_rsp_data,

    output logic                    wr_rsp_valid,
    input  logic                    wr_rsp_ready,
    output logic [ID_WIDTH-1:0]     wr_rsp_id
);

    localparam int PTR_W = $clog2(WR_ACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WR_ACK_DEPTH);

    typedef enum logic {GRANT_RD, GRANT_WR} grant_e;

    grant_e                  last_grant;
    logic                    aw_full, w_full;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_be;

    logic [ID_WIDTH-1:0]     ack_mem [WR_ACK_DEPTH];
    logic [PTR_W-1:0]        ack_wptr, ack_rptr;
    logic [CNT_W-1:0]        ack_count;
    logic [CNT_W-1:0]        credit_used;

    logic slot_free, wr_eligible, rd_wins, rd_grant, wr_grant;
    logic aw_fire, w_fire, ack_push, ack_pop;
    logic [TAG_WIDTH-1:0] rd_tag, wr_tag;

    // Outstanding write credit covers both queued acks and a write still parked in the bus slot.
    assign credit_used = ack_count + CNT_W'(mem_req_valid && mem_req_rw);
    assign wr_eligible = aw_full && w_full && (credit_used < DEPTH_C);
    assign slot_free   = !mem_req_valid || mem_req_ready;

    // Read priority is independent of rd_req_valid so rd_req_ready never depends on it.
    assign rd_wins      = !wr_eligible || (last_grant == GRANT_WR);
    assign rd_req_ready = !reset && slot_free && rd_wins;
    assign rd_grant     = rd_req_valid && rd_req_ready;
    assign wr_grant     = !reset && slot_free && wr_eligible &&
                          (!rd_req_valid || (last_grant == GRANT_RD));

    assign wr_req_ready  = !reset && !aw_full;
    assign wr_data_ready = !reset && !w_full;
    assign aw_fire       = wr_req_valid && wr_req_ready;
    assign w_fire        = wr_data_valid && wr_data_ready;

    always_comb begin
        rd_tag = '0;
        rd_tag[ID_WIDTH-1:0] = rd_req_id;
        wr_tag = '0;
        wr_tag[TAG_WIDTH-1] = 1'b1;
        wr_tag[ID_WIDTH-1:0] = aw_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            mem_req_valid <= 1'b0;
            last_grant    <= GRANT_WR;
        end else begin
            if (aw_fire) aw_full <= 1'b1;
            if (w_fire)  w_full  <= 1'b1;
            if (rd_grant) begin
                mem_req_valid <= 1'b1;
                last_grant    <= GRANT_RD;
            end else if (wr_grant) begin
                mem_req_valid <= 1'b1;
                aw_full       <= 1'b0;
                w_full        <= 1'b0;
                last_grant    <= GRANT_WR;
            end else if (mem_req_ready) begin
                mem_req_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_fire) begin
            aw_addr <= wr_req_addr;
            aw_id   <= wr_req_id;
        end
        if (w_fire) begin
            w_data <= wr_data;
            w_be   <= wr_be;
        end
        if (rd_grant) begin
            mem_req_rw     <= 1'b0;
            mem_req_addr   <= rd_req_addr;
            mem_req_data   <= '0;
            mem_req_byteen <= '1;
            mem_req_tag    <= rd_tag;
        end else if (wr_grant) begin
            mem_req_rw     <= 1'b1;
            mem_req_addr   <= aw_addr;
            mem_req_data   <= w_data;
            mem_req_byteen <= w_be;
            mem_req_tag    <= wr_tag;
        end
    end

    // Local write acknowledge FIFO, fed as each write leaves on the bus.
    assign ack_push     = mem_req_valid && mem_req_ready && mem_req_rw;
    assign wr_rsp_valid = (ack_count != '0);
    assign ack_pop      = wr_rsp_valid && wr_rsp_ready;
    assign wr_rsp_id    = ack_mem[ack_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_wptr  <= '0;
            ack_rptr  <= '0;
            ack_count <= '0;
        end else begin
            if (ack_push) ack_wptr <= ack_wptr + 1'b1;
            if (ack_pop)  ack_rptr <= ack_rptr + 1'b1;
            if (ack_push && !ack_pop)      ack_count <= ack_count + 1'b1;
            else if (!ack_push && ack_pop) ack_count <= ack_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ack_push) ack_mem[ack_wptr] <= mem_req_tag[ID_WIDTH-1:0];
    end

    // Write-tagged responses are swallowed; reads pass straight through.
    assign rd_rsp_valid  = mem_rsp_valid && !mem_rsp_tag[TAG_WIDTH-1];
    assign mem_rsp_ready = !reset && (mem_rsp_tag[TAG_WIDTH-1] || rd_rsp_ready);
    assign rd_rsp_id     = mem_rsp_tag[ID_WIDTH-1:0];
    assign rd_rsp_data   = mem_rsp_data;

endmodule

// File: tb/tb_vx_hpdcache_mem_req_arb.sv
// Randomized bench for vx_hpdcache_mem_req_arb against a queue-based transaction model.
module tb_vx_hpdcache_mem_req_arb;

    localparam int AW    = 32;
    localparam int DW    = 512;
    localparam int BW    = DW / 8;
    localparam int IW    = 4;
    localparam int TW    = IW + 1;
    localparam int DEPTH = 4;
    localparam int CYCLES = 4000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rd_req_valid = 1'b0, rd_req_ready;
    logic [AW-1:0] rd_req_addr = '0;
    logic [IW-1:0] rd_req_id = '0;
    logic wr_req_valid = 1'b0, wr_req_ready;
    logic [AW-1:0] wr_req_addr = '0;
    logic [IW-1:0] wr_req_id = '0;
    logic wr_data_valid = 1'b0, wr_data_ready;
    logic [DW-1:0] wr_data = '0;
    logic [BW-1:0] wr_be = '0;
    logic mem_req_valid, mem_req_ready = 1'b0, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [BW-1:0] mem_req_byteen;
    logic [TW-1:0] mem_req_tag;
    logic mem_rsp_valid = 1'b0, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_data = '0;
    logic [TW-1:0] mem_rsp_tag = '0;
    logic rd_rsp_valid, rd_rsp_ready = 1'b0;
    logic [IW-1:0] rd_rsp_id;
    logic [DW-1:0] rd_rsp_data;
    logic wr_rsp_valid, wr_rsp_ready = 1'b0;
    logic [IW-1:0] wr_rsp_id;

    vx_hpdcache_mem_req_arb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TAG_WIDTH(TW), .WR_ACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_id(rd_req_id),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_id(wr_req_id),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .wr_data(wr_data), .wr_be(wr_be),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen),
        .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_id(rd_rsp_id), .rd_rsp_data(rd_rsp_data),
        .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready),
        .wr_rsp_id(wr_rsp_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Transaction-level model: pending write halves, queued acks, one bus slot.
    typedef struct { logic [AW-1:0] addr; logic [IW-1:0] id; } aw_t;
    typedef struct { logic [DW-1:0] data; logic [BW-1:0] be; } w_t;
    aw_t awq[$];
    w_t  wq[$];
    logic [IW-1:0] ackq[$];
    bit m_valid, m_rw, last_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [BW-1:0] m_be;
    logic [TW-1:0] m_tag;

    initial begin
        int rsp_pct;
        bit slot_free, elig, exp_rd_ready, rd_grant, wr_grant, aw_take, w_take;
        int credit;
        rsp_pct = 80;
        last_wr = 1'b1;
        m_valid = 1'b0;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc % 64 == 0) rsp_pct = ($urandom_range(0, 2) == 0) ? 0 : 80;
            reset         = (cyc < 2) || ($urandom_range(0, 199) == 0);
            rd_req_valid  = ($urandom_range(0, 99) < 60);
            rd_req_addr   = $urandom;
            rd_req_id     = IW'($urandom);
            wr_req_valid  = ($urandom_range(0, 99) < 50);
            wr_req_addr   = $urandom;
            wr_req_id     = IW'($urandom);
            wr_data_valid = ($urandom_range(0, 99) < 50);
            wr_data       = rand_data();
            wr_be         = {$urandom, $urandom};
            mem_req_ready = ($urandom_range(0, 99) < 70);
            wr_rsp_ready  = ($urandom_range(0, 99) < rsp_pct);
            mem_rsp_valid = ($urandom_range(0, 1) == 1);
            mem_rsp_tag   = TW'($urandom);
            mem_rsp_data  = rand_data();
            rd_rsp_ready  = ($urandom_range(0, 99) < 70);
            #1;

            credit    = ackq.size() + ((m_valid && m_rw) ? 1 : 0);
            elig      = (awq.size() == 1) && (wq.size() == 1) && (credit < DEPTH);
            slot_free = !m_valid || mem_req_ready;
            exp_rd_ready = !reset && slot_free && (!elig || last_wr);
            rd_grant  = exp_rd_ready && rd_req_valid;
            wr_grant  = !reset && slot_free && elig && (!rd_req_valid || !last_wr);
            aw_take   = !reset && wr_req_valid && (awq.size() == 0);
            w_take    = !reset && wr_data_valid && (wq.size() == 0);

            check_val("rd_req_ready", DW'(rd_req_ready), DW'(exp_rd_ready));
            check_val("wr_req_ready", DW'(wr_req_ready), DW'(!reset && awq.size() == 0));
            check_val("wr_data_ready", DW'(wr_data_ready), DW'(!reset && wq.size() == 0));
            check_val("mem_rsp_ready", DW'(mem_rsp_ready),
                      DW'(!reset && (mem_rsp_tag[TW-1] || rd_rsp_ready)));
            check_val("rd_rsp_valid", DW'(rd_rsp_valid), DW'(mem_rsp_valid && !mem_rsp_tag[TW-1]));
            if (rd_rsp_valid) begin
                check_val("rd_rsp_id", DW'(rd_rsp_id), DW'(mem_rsp_tag[IW-1:0]));
                check_val("rd_rsp_data", rd_rsp_data, mem_rsp_data);
            end
            if (cyc >= 2) begin
                check_val("mem_req_valid", DW'(mem_req_valid), DW'(m_valid));
                if (m_valid) begin
                    check_val("mem_req_rw", DW'(mem_req_rw), DW'(m_rw));
                    check_val("mem_req_addr", DW'(mem_req_addr), DW'(m_addr));
                    check_val("mem_req_tag", DW'(mem_req_tag), DW'(m_tag));
                    check_val("mem_req_byteen", DW'(mem_req_byteen), DW'(m_be));
                    check_val("mem_req_data", mem_req_data, m_data);
                end
                check_val("wr_rsp_valid", DW'(wr_rsp_valid), DW'(ackq.size() != 0));
                if (ackq.size() != 0) check_val("wr_rsp_id", DW'(wr_rsp_id), DW'(ackq[0]));
            end

            @(posedge clk);
            if (reset) begin
                awq.delete();
                wq.delete();
                ackq.delete();
                m_valid = 1'b0;
                last_wr = 1'b1;
            end else begin
                if (ackq.size() != 0 && wr_rsp_ready) void'(ackq.pop_front());
                if (m_valid && mem_req_ready && m_rw) ackq.push_back(m_tag[IW-1:0]);
                if (rd_grant) begin
                    m_valid = 1'b1; m_rw = 1'b0; m_addr = rd_req_addr;
                    m_data = '0; m_be = '1; m_tag = {1'b0, rd_req_id};
                    last_wr = 1'b0;
                end else if (wr_grant) begin
                    m_valid = 1'b1; m_rw = 1'b1; m_addr = awq[0].addr;
                    m_data = wq[0].data; m_be = wq[0].be; m_tag = {1'b1, awq[0].id};
                    awq.delete();
                    wq.delete();
                    last_wr = 1'b1;
                end else if (mem_req_ready) begin
                    m_valid = 1'b0;
                end
                if (aw_take) awq.push_back('{addr: wr_req_addr, id: wr_req_id});
                if (w_take)  wq.push_back('{data: wr_data, be: wr_be});
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
